// File: rtl/audio_sigma_delta_dac.sv
// Stereo audio DAC front end: fixed-rate sample-and-hold with attenuation/mute,
// followed by one first-order sigma-delta modulator per channel.
module audio_sigma_delta_dac #(
    parameter int WIDTH      = 16,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] audio_l,
    input  logic signed [WIDTH-1:0] audio_r,
    input  logic                    mute,
    input  logic [3:0]              vol,
    output logic                    sample_tick,
    output logic                    dac_l,
    output logic                    dac_r
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    // Signed sample -> attenuated offset-binary level for the modulator.
    function automatic logic [WIDTH-1:0] conv(
        input logic signed [WIDTH-1:0] s,
        input logic [3:0]              sh,
        input logic                    m
    );
        logic signed [WIDTH-1:0] t;
        t = s >>> sh;
        if (m) return MIDSCALE;
        return {~t[WIDTH-1], t[WIDTH-2:0]};
    endfunction

    // The carry out of the accumulator is the output bit; the sum cannot overflow.
    function automatic logic [WIDTH:0] mod_step(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] hold
    );
        return {1'b0, acc} + {1'b0, hold};
    endfunction

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             tick_q,   tick_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic [WIDTH-1:0] acc_l_q,  acc_l_d;
    logic [WIDTH-1:0] acc_r_q,  acc_r_d;
    logic             dac_l_q,  dac_l_d;
    logic             dac_r_q,  dac_r_d;
    logic             capture;
    logic [WIDTH:0]   sum_l;
    logic [WIDTH:0]   sum_r;

    // Divider and sample-and-hold
    always_comb begin
        capture  = (cnt_q == CNT_LAST);
        cnt_d    = capture ? '0 : cnt_q + CNT_W'(1);
        tick_d   = capture;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (capture) begin
            hold_l_d = conv(audio_l, vol, mute);
            hold_r_d = conv(audio_r, vol, mute);
        end
    end

    // Modulators run from the registered hold, so a capture shows up one edge later
    always_comb begin
        sum_l   = mod_step(acc_l_q, hold_l_q);
        sum_r   = mod_step(acc_r_q, hold_r_q);
        acc_l_d = sum_l[WIDTH-1:0];
        acc_r_d = sum_r[WIDTH-1:0];
        dac_l_d = sum_l[WIDTH];
        dac_r_d = sum_r[WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            hold_l_q <= MIDSCALE;
            hold_r_q <= MIDSCALE;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            dac_l_q  <= 1'b0;
            dac_r_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            dac_l_q  <= dac_l_d;
            dac_r_q  <= dac_r_d;
        end
    end

    assign sample_tick = tick_q;
    assign dac_l       = dac_l_q;
    assign dac_r       = dac_r_q;

endmodule

// File: tb/tb_audio_sigma_delta_dac.sv
// Directed bench for audio_sigma_delta_dac at WIDTH=16, SAMPLE_DIV=16.
module tb_audio_sigma_delta_dac;

    localparam int WIDTH      = 16;
    localparam int SAMPLE_DIV = 16;

    logic                    clk;
    logic                    reset;
    logic signed [WIDTH-1:0] audio_l;
    logic signed [WIDTH-1:0] audio_r;
    logic                    mute;
    logic [3:0]              vol;
    logic                    sample_tick;
    logic                    dac_l;
    logic                    dac_r;

    int errors = 0;
    int checks = 0;

    audio_sigma_delta_dac #(.WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .mute        (mute),
        .vol         (vol),
        .sample_tick (sample_tick),
        .dac_l       (dac_l),
        .dac_r       (dac_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges taken until sample_tick is seen high; -1 if it never comes.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (sample_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int ones_l;
        int ones_r;
        int bad_win;
        int win;
        logic [3:0] hist;
        logic d1;
        logic d2;

        reset   = 1'b1;
        audio_l = '0;
        audio_r = '0;
        mute    = 1'b0;
        vol     = 4'd0;

        // 1: reset state and startup behaviour
        steps(3);
        chk("rst_tick", {31'd0, sample_tick}, 32'd0);
        chk("rst_dac_l", {31'd0, dac_l}, 32'd0);
        chk("rst_dac_r", {31'd0, dac_r}, 32'd0);
        chk("rst_hold_l", {16'd0, dut.hold_l_q}, 32'h8000);
        chk("rst_hold_r", {16'd0, dut.hold_r_q}, 32'h8000);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k <= 8) begin
                chk("mid_dac_l", {31'd0, dac_l}, (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("mid_dac_r", {31'd0, dac_r}, (k % 2 == 0) ? 32'd1 : 32'd0);
            end
            chk("first_tick", {31'd0, sample_tick}, (k == 16) ? 32'd1 : 32'd0);
        end
        chk("hold_zero_in", {16'd0, dut.hold_l_q}, 32'h8000);
        step();
        chk("tick_pulse_1cyc", {31'd0, sample_tick}, 32'd0);
        steps(14);
        chk("tick_pre", {31'd0, sample_tick}, 32'd0);
        step();
        chk("tick_period", {31'd0, sample_tick}, 32'd1);

        // 2: full-scale positive / negative
        audio_l = 16'sh7FFF;
        audio_r = 16'sh8000;
        wait_tick(n);
        chk("tick_gap_2", n, 32'd16);
        chk("hold_l_7fff", {16'd0, dut.hold_l_q}, 32'hFFFF);
        chk("hold_r_8000", {16'd0, dut.hold_r_q}, 32'h0000);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < 65536; i++) begin
            step();
            ones_l += int'(dac_l);
            ones_r += int'(dac_r);
        end
        chk("ones_l_ffff", ones_l, 32'd65535);
        chk("ones_r_0000", ones_r, 32'd0);

        // 3: three-quarter scale
        audio_l = 16'sh4000;
        wait_tick(n);
        chk("tick_gap_3", n, 32'd16);
        chk("hold_l_c000", {16'd0, dut.hold_l_q}, 32'hC000);
        ones_l  = 0;
        bad_win = 0;
        hist    = 4'd0;
        for (int i = 0; i < 4096; i++) begin
            step();
            ones_l += int'(dac_l);
            hist = {hist[2:0], dac_l};
            if (i >= 3) begin
                win = int'(hist[0]) + int'(hist[1]) + int'(hist[2]) + int'(hist[3]);
                if (win < 2 || win > 4) bad_win++;
            end
        end
        chk("ones_l_c000", ones_l, 32'd3072);
        chk("win4_density", bad_win, 32'd0);

        // 4: mute/vol only take effect at capture
        wait_tick(n);
        chk("tick_gap_4", n, 32'd16);
        steps(5);
        mute = 1'b1;
        steps(10);
        chk("mute_not_yet", {16'd0, dut.hold_l_q}, 32'hC000);
        chk("no_tick_cnt15", {31'd0, sample_tick}, 32'd0);
        step();
        chk("mute_tick", {31'd0, sample_tick}, 32'd1);
        chk("mute_hold_l", {16'd0, dut.hold_l_q}, 32'h8000);
        chk("mute_hold_r", {16'd0, dut.hold_r_q}, 32'h8000);
        mute    = 1'b0;
        vol     = 4'd1;
        audio_l = 16'sh7FFF;
        steps(15);
        chk("vol1_not_yet", {16'd0, dut.hold_l_q}, 32'h8000);
        step();
        chk("vol1_tick", {31'd0, sample_tick}, 32'd1);
        chk("vol1_hold_l", {16'd0, dut.hold_l_q}, 32'hBFFF);
        chk("vol1_hold_r", {16'd0, dut.hold_r_q}, 32'h4000);
        vol     = 4'd15;
        audio_l = 16'sh8000;
        steps(3);
        audio_l = 16'sh1234;
        mute    = 1'b1;
        vol     = 4'd0;
        steps(5);
        chk("glitch_hold", {16'd0, dut.hold_l_q}, 32'hBFFF);
        audio_l = 16'sh8000;
        mute    = 1'b0;
        vol     = 4'd15;
        steps(8);
        chk("vol15_tick", {31'd0, sample_tick}, 32'd1);
        chk("vol15_hold_l", {16'd0, dut.hold_l_q}, 32'h7FFF);
        chk("vol15_hold_r", {16'd0, dut.hold_r_q}, 32'h7FFF);

        // 5: asynchronous reset mid-period
        audio_l = 16'sh4000;
        vol     = 4'd0;
        wait_tick(n);
        chk("tick_gap_5", n, 32'd16);
        chk("pre_rst_hold", {16'd0, dut.hold_l_q}, 32'hC000);
        steps(9);
        reset = 1'b1;
        #1;
        chk("arst_tick", {31'd0, sample_tick}, 32'd0);
        chk("arst_dac_l", {31'd0, dac_l}, 32'd0);
        chk("arst_dac_r", {31'd0, dac_r}, 32'd0);
        chk("arst_hold_l", {16'd0, dut.hold_l_q}, 32'h8000);
        step();
        reset = 1'b0;
        d1 = 1'bx;
        d2 = 1'bx;
        n  = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 1) d1 = dac_l;
            if (i == 2) d2 = dac_l;
            if (sample_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("post_rst_dac1", {31'd0, d1}, 32'd0);
        chk("post_rst_dac2", {31'd0, d2}, 32'd1);
        chk("post_rst_tick", n, 32'd16);
        chk("post_rst_hold", {16'd0, dut.hold_l_q}, 32'hC000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
